// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] EBREAK_OP    = 32'h0010_0073;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port plus decode handshake of the fetch stage.
interface fetch_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 10
);
   logic             re_o;
   logic [DEPTH-1:0] addread_o;
   logic [WIDTH-1:0] datoread_i;
   logic             redirect_i;
   logic [31:0]      target_i;
   logic [WIDTH-1:0] instr_o;
   logic [31:0]      pc_o;
   logic             valid_o;
   logic             ready_i;
   logic             misalign_o;
   logic             halted_o;

   modport master (
      output re_o, addread_o, instr_o, pc_o, valid_o, misalign_o, halted_o,
      input  datoread_i, redirect_i, target_i, ready_i
   );

   modport slave (
      input  re_o, addread_o, instr_o, pc_o, valid_o, misalign_o, halted_o,
      output datoread_i, redirect_i, target_i, ready_i
   );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with increment/redirect select and target alignment check.
module fetch_unit_pc_reg
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       DEPTH    = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              advance_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DEPTH-1:0]  addr_o,
   output logic              misalign_c_o
);

   logic [ADDR_W-1:0] pc_q, pc_d;

   assign misalign_c_o = !is_word_aligned(target_i);

   // A misaligned redirect leaves the PC untouched; the stage faults instead.
   always_comb begin
      pc_d = pc_q;
      if (load_i && !misalign_c_o) begin
         pc_d = target_i;
      end else if (advance_i) begin
         pc_d = pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o   = pc_q;
   assign addr_o = pc_q[DEPTH+1:2];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory read port, output register toward decode.
// Define FETCH_HALT_EN to stop fetching after delivering an EBREAK word.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       WIDTH    = INSTR_W,
   parameter int unsigned       DEPTH    = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   fetch_unit_if.master  bus
);

   fetch_state_e      state_q;
   logic [WIDTH-1:0]  instr_q;
   logic [ADDR_W-1:0] pc_out_q;
   logic              valid_q;
   logic              misalign_q;

   logic [ADDR_W-1:0] pc;
   logic              fetch;
   logic              run_redirect;
   logic              bad_target;
   logic              halt_hit;
   logic              advance;

   assign run_redirect = (state_q == ST_RUN) && bus.redirect_i;
   assign fetch        = (state_q == ST_RUN) && !bus.redirect_i && (!valid_q || bus.ready_i);

`ifdef FETCH_HALT_EN
   logic halted_q;
   assign halt_hit     = bus.datoread_i == WIDTH'(EBREAK_OP);
   assign bus.halted_o = halted_q;
`else
   assign halt_hit     = 1'b0;
   assign bus.halted_o = 1'b0;
`endif

   // An EBREAK capture freezes the PC on the word it came from.
   assign advance = fetch && !halt_hit;

   fetch_unit_pc_reg #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .advance_i    (advance),
      .load_i       (run_redirect),
      .target_i     (bus.target_i),
      .pc_o         (pc),
      .addr_o       (bus.addread_o),
      .misalign_c_o (bad_target)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_BOOT;
         instr_q    <= '0;
         pc_out_q   <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
`ifdef FETCH_HALT_EN
         halted_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_BOOT: begin
               state_q <= ST_RUN;
               if (valid_q && bus.ready_i) valid_q <= 1'b0;
            end
            ST_RUN: begin
               if (run_redirect) begin
                  valid_q <= 1'b0;
                  if (bad_target) begin
                     state_q    <= ST_FAULT;
                     misalign_q <= 1'b1;
                  end
               end else if (fetch) begin
                  instr_q  <= bus.datoread_i;
                  pc_out_q <= pc;
                  valid_q  <= 1'b1;
`ifdef FETCH_HALT_EN
                  if (halt_hit) begin
                     state_q  <= ST_HALT;
                     halted_q <= 1'b1;
                  end
`endif
               end
            end
            default: begin
               if (valid_q && bus.ready_i) valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.re_o       = fetch;
   assign bus.instr_o    = instr_q;
   assign bus.pc_o       = pc_out_q;
   assign bus.valid_o    = valid_q;
   assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a cycle-step reference model.
module tb_fetch_unit;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 10;
   localparam int unsigned WORDS = 1 << DEPTH;
   localparam logic [31:0] EBRK  = 32'h0010_0073;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   logic [31:0] mem [WORDS];
   assign bus.datoread_i = mem[bus.addread_o];

   int checks = 0;
   int errors = 0;

   // Model: phase 0 boot, 1 run, 2 fault, 3 halt
   int          m_phase;
   logic [31:0] m_pc, m_instr, m_pcout;
   bit          m_valid, m_mis, m_halt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit halt_enabled();
`ifdef FETCH_HALT_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0;
      m_valid = 0; m_mis = 0; m_halt = 0;
   endtask

   function automatic bit model_fetch(input bit rdy, input bit redir);
      return (m_phase == 1) && !redir && (!m_valid || rdy);
   endfunction

   task automatic model_step(input bit rdy, input bit redir, input logic [31:0] tgt);
      logic [31:0] w;
      if (m_phase == 1) begin
         if (redir) begin
            m_valid = 0;
            if (tgt % 4 != 0) begin m_phase = 2; m_mis = 1; end
            else m_pc = tgt;
         end else if (!m_valid || rdy) begin
            w = mem[(m_pc >> 2) % WORDS];
            m_instr = w; m_pcout = m_pc; m_valid = 1;
            if (halt_enabled() && w == EBRK) begin m_phase = 3; m_halt = 1; end
            else m_pc = m_pc + 32'd4;
         end
      end else begin
         if (m_valid && rdy) m_valid = 0;
         if (m_phase == 0) m_phase = 1;
      end
   endtask

   task automatic check_all(input bit rdy, input bit redir);
      chk("re_o", 32'(bus.re_o), 32'(model_fetch(rdy, redir)));
      chk("addread_o", 32'(bus.addread_o), (m_pc >> 2) % WORDS);
      chk("valid_o", 32'(bus.valid_o), 32'(m_valid));
      chk("instr_o", bus.instr_o, m_instr);
      chk("pc_o", bus.pc_o, m_pcout);
      chk("misalign_o", 32'(bus.misalign_o), 32'(m_mis));
      chk("halted_o", 32'(bus.halted_o), 32'(m_halt));
   endtask

   // One clock: starts and ends just after a falling edge.
   task automatic cyc(input bit rdy, input bit redir, input logic [31:0] tgt);
      bus.ready_i = rdy; bus.redirect_i = redir; bus.target_i = tgt;
      #1;
      check_all(rdy, redir);
      @(posedge clk);
      model_step(rdy, redir, tgt);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic reset_pulse();
      #2;
      rst_n = 1'b0;
      bus.redirect_i = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 32'(bus.valid_o), 32'h0);
      chk("rst_pc_o", bus.pc_o, 32'h0);
      chk("rst_instr", bus.instr_o, 32'h0);
      chk("rst_mis", 32'(bus.misalign_o), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] w, tgt;
      bit rdy, redir;
      for (int i = 0; i < int'(WORDS); i++) begin
         w = $urandom;
         if (w == EBRK) w = w ^ 32'h1;
         mem[i] = w;
      end
      mem[0] = 32'h0050_0293;
      mem[1] = 32'h01E0_0313;
      mem[2] = 32'h0062_83B3;
      mem[3] = EBRK;
      mem[4] = 32'h0000_0013;

      bus.ready_i = 1'b0; bus.redirect_i = 1'b0; bus.target_i = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_all(1'b0, 1'b0);
      rst_n = 1'b1;

      // Straight-line fetch from reset
      cyc(1, 0, 0);
      chk("boot_no_valid", 32'(bus.valid_o), 32'h0);
      cyc(1, 0, 0);
      chk("w0_instr", bus.instr_o, 32'h0050_0293);
      chk("w0_pc", bus.pc_o, 32'h0);
      cyc(1, 0, 0);
      chk("w1_instr", bus.instr_o, 32'h01E0_0313);
      chk("w1_pc", bus.pc_o, 32'h4);

      // Decode stall
      repeat (3) cyc(0, 0, 0);
      chk("stall_instr", bus.instr_o, 32'h01E0_0313);
      chk("stall_pc", bus.pc_o, 32'h4);
      cyc(1, 0, 0);
      chk("w2_instr", bus.instr_o, 32'h0062_83B3);
      chk("w2_pc", bus.pc_o, 32'h8);

      // Redirect while stalled
      cyc(0, 1, 32'h8);
      chk("redir_flush", 32'(bus.valid_o), 32'h0);
      cyc(1, 0, 0);
      chk("redir_pc", bus.pc_o, 32'h8);
      chk("redir_instr", bus.instr_o, 32'h0062_83B3);

      // EBREAK word at 0xC
      cyc(1, 0, 0);
      chk("ebrk_instr", bus.instr_o, EBRK);
      chk("ebrk_pc", bus.pc_o, 32'hC);
      cyc(1, 0, 0);
      if (halt_enabled()) begin
         chk("halt_stop", 32'(bus.valid_o), 32'h0);
         chk("halt_flag", 32'(bus.halted_o), 32'h1);
      end else begin
         chk("post_ebrk_pc", bus.pc_o, 32'h10);
         chk("post_ebrk_instr", bus.instr_o, 32'h0000_0013);
      end
      cyc(1, 0, 0);

      // Mid-stream reset, then misaligned redirect
      reset_pulse();
      repeat (3) cyc(1, 0, 0);
      chk("resume_pc", bus.pc_o, 32'h4);
      cyc(1, 1, 32'h6);
      chk("mis_flag", 32'(bus.misalign_o), 32'h1);
      chk("mis_flush", 32'(bus.valid_o), 32'h0);
      cyc(1, 1, 32'h0);
      cyc(1, 0, 32'h0);
      chk("fault_valid", 32'(bus.valid_o), 32'h0);
      chk("fault_mis", 32'(bus.misalign_o), 32'h1);

      // Randomized traffic
      reset_pulse();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            reset_pulse();
         end else begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            tgt   = 32'($urandom_range(0, 2 * WORDS - 1)) << 2;
            if ($urandom_range(0, 39) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            cyc(rdy, redir, tgt);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage placed directly upstream of the word-addressed instruction memory. Holds the program counter and drives the memory read port. Captures each returned instruction word into an output register with a valid/ready handshake toward decode. Supports a one-cycle redirect (branch/jump) with flush, and traps misaligned targets.

## Interface
- WIDTH, 32, instruction word width
- DEPTH, 10, memory address bits (2^DEPTH words)
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- re_o  out  1  memory read enable
- addread_o  out  DEPTH  word address = pc[DEPTH+1:2]
- datoread_i  in  WIDTH  combinational read data from memory
- redirect_i  in  1  load target_i into PC, flush held instruction
- target_i  in  32  redirect byte address
- instr_o  out  WIDTH  fetched instruction
- pc_o  out  32  byte address of instr_o
- valid_o  out  1  instr_o/pc_o valid
- ready_i  in  1  decode accepts when valid_o && ready_i
- misalign_o  out  1  sticky: redirect target not word-aligned
- halted_o  out  1  sticky: fetch stopped by EBREAK (see Configuration)

## Operation
- States: BOOT, RUN, FAULT, HALT (HALT only with the macro).
- Reset: state=BOOT, pc=RESET_PC, instr_o=0, pc_o=0, valid_o=0, misalign_o=0, halted_o=0, re_o=0.
- BOOT -> RUN after one cycle, unconditionally; no fetch in BOOT.
- fetch = (state==RUN) && !redirect_i && (!valid_o || ready_i); re_o=fetch; addread_o always reflects pc.
- On fetch: instr_o<=datoread_i, pc_o<=pc, valid_o<=1, pc<=pc+4 (32-bit modulo; addresses above the memory range alias by truncation).
- valid_o && !ready_i && !redirect_i: instr_o, pc_o, valid_o, pc all hold.
- valid_o && ready_i with no fetch (BOOT/FAULT/HALT): valid_o<=0.
- redirect_i (priority over everything, in RUN): valid_o<=0 (flush, regardless of ready_i), pc<=target_i. If target_i[1:0]!=0: state<=FAULT, misalign_o<=1, pc unchanged.
- redirect_i in BOOT, FAULT or HALT: ignored.
- FAULT, HALT: terminal until rst_ni asserted; no further fetches.
- rst_ni asserted mid-operation: all outputs return to reset values immediately (asynchronously); the in-flight instruction is discarded.

## Timing
- Fetch latency: pc presented combinationally, instruction visible on instr_o one edge later.
- Throughput: one instruction per cycle while ready_i=1.
- First valid_o after reset release: rising edge 2 (edge 1 leaves BOOT, edge 2 captures word at RESET_PC).
- Redirect at cycle n: valid_o=0 in cycle n+1, target instruction valid in cycle n+2.
- misalign_o rises on the edge that samples the bad redirect.

## Configuration
- FETCH_HALT_EN defined: a captured word equal to 32'h0010_0073 (EBREAK) is delivered normally with valid_o. On the same edge, state<=HALT and halted_o<=1; pc is not advanced.
- FETCH_HALT_EN undefined: EBREAK is fetched like any word, HALT state absent, halted_o tied to 0.

## Structure
- Shared package: state encoding typedef, EBREAK opcode constant, RESET_PC default, instruction width constant.
- One natural sub-module: pc_reg (PC register with increment/redirect mux and alignment check); output register and FSM stay in fetch_unit.

## Test plan
- Reset, memory preloaded with 0x00500293, 0x01E00313, 0x006283B3; ready_i=1 -> instr_o on three consecutive cycles from edge 2 with pc_o 0x0, 0x4, 0x8.
- ready_i=0 for 3 cycles while valid_o=1 with instr_o=0x01E00313 -> instr_o/pc_o=0x4 held, re_o=0, no PC advance; on release, next is 0x006283B3 at 0x8.
- redirect_i with target_i=0x8 while valid_o=1, ready_i=0 -> valid_o=0 next cycle, then pc_o=0x8, instr_o=0x006283B3.
- redirect_i with target_i=0x6 -> misalign_o=1, valid_o=0 thereafter, re_o=0; redirect to 0x0 afterwards ignored.
- rst_ni pulsed low mid-stream -> valid_o=0 and pc_o=0 without a clock edge; fetch resumes at RESET_PC.
- With FETCH_HALT_EN, word 0x00100073 at 0xC -> delivered with pc_o=0xC, halted_o=1, no further valid_o; without macro, fetch continues to 0x10.
